// File: rtl/hiscore_ram_arbiter_if.sv
// Hiscore engine access port: request, address and write data toward the arbiter,
// completion strobe and read data back to the engine.
interface hiscore_ram_arbiter_if #(
   parameter int AW = 16
);
   logic          hs_req;
   logic [AW-1:0] hs_addr;
   logic          hs_we;
   logic [7:0]    hs_wdata;
   logic [7:0]    hs_rdata;
   logic          hs_ack;

   modport master (
      output hs_req, hs_addr, hs_we, hs_wdata,
      input  hs_rdata, hs_ack
   );

   modport slave (
      input  hs_req, hs_addr, hs_we, hs_wdata,
      output hs_rdata, hs_ack
   );
endinterface

// File: rtl/hiscore_ram_arbiter.sv
// Shares a single-port work RAM between the CPU and the hiscore engine by pausing
// the CPU around engine accesses.
//
//  state   | meaning
//  --------+------------------------------------------------------------------
//  IDLE    | CPU owns the RAM, waiting for an engine request
//  PREQ    | pause_req raised, waiting for cpu_paused (timeout -> hs_err)
//  ACCESS  | engine owns the RAM, address/data/we presented for one cycle
//  ACK     | hs_ack strobe, read data captured from ram_q
//  HOLD    | CPU kept paused for a few idle cycles in case another access follows
//  RELEASE | pause_req dropped, ownership back to the CPU
module hiscore_ram_arbiter #(
   parameter int AW       = 16,
   parameter int HOLD_CYC = 8,
   parameter int TMO_CYC  = 1024
) (
   input  logic                 clk_sys,
   input  logic                 reset_n,
   input  logic [AW-1:0]        cpu_addr,
   input  logic [7:0]           cpu_wdata,
   input  logic                 cpu_we,
   output logic [7:0]           cpu_rdata,
   hiscore_ram_arbiter_if.slave hs,
   output logic                 pause_req,
   input  logic                 cpu_paused,
   output logic [AW-1:0]        ram_addr,
   output logic [7:0]           ram_wdata,
   output logic                 ram_we,
   input  logic [7:0]           ram_q,
   output logic                 hs_err
);

   localparam int TW = $clog2(TMO_CYC) + 1;
   localparam int HW = $clog2(HOLD_CYC) + 1;
   localparam logic [TW-1:0] TMO_LAST  = TW'(TMO_CYC - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);

   typedef enum logic [2:0] {
      IDLE,
      PREQ,
      ACCESS,
      ACK,
      HOLD,
      RELEASE
   } state_t;

   state_t        state;
   logic          owner_hs;
   logic [TW-1:0] wait_cnt;
   logic [HW-1:0] hold_cnt;
   logic [1:0]    rst_sync;
   logic          rst_int_n;

   // Assertion is immediate; release reaches the FSM only after two clock edges.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         rst_sync <= 2'b00;
      end else begin
         rst_sync <= {rst_sync[0], 1'b1};
      end
   end

   assign rst_int_n = rst_sync[1];

   always_ff @(posedge clk_sys or negedge rst_int_n) begin
      if (!rst_int_n) begin
         state       <= IDLE;
         owner_hs    <= 1'b0;
         pause_req   <= 1'b0;
         hs.hs_ack   <= 1'b0;
         hs.hs_rdata <= 8'h00;
         hs_err      <= 1'b0;
         wait_cnt    <= '0;
         hold_cnt    <= '0;
      end else begin
         hs.hs_ack <= 1'b0;
         case (state)
            IDLE: begin
               if (hs.hs_req) begin
                  state     <= PREQ;
                  pause_req <= 1'b1;
                  wait_cnt  <= '0;
               end
            end
            PREQ: begin
               if (cpu_paused) begin
                  state    <= ACCESS;
                  owner_hs <= 1'b1;
               end else if (!hs.hs_req) begin
                  state     <= RELEASE;
                  pause_req <= 1'b0;
               end else if (wait_cnt == TMO_LAST) begin
                  state     <= RELEASE;
                  pause_req <= 1'b0;
                  hs_err    <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            ACCESS: begin
               state     <= ACK;
               hs.hs_ack <= 1'b1;
            end
            ACK: begin
               hs.hs_rdata <= ram_q;
               if (hs.hs_req && cpu_paused) begin
                  state <= ACCESS;
               end else if (hs.hs_req) begin
                  // CPU slipped out of pause: re-handshake before touching the RAM again
                  state    <= PREQ;
                  owner_hs <= 1'b0;
                  wait_cnt <= '0;
               end else begin
                  state    <= HOLD;
                  hold_cnt <= '0;
               end
            end
            HOLD: begin
               if (hs.hs_req && cpu_paused) begin
                  state <= ACCESS;
               end else if (hs.hs_req) begin
                  state    <= PREQ;
                  owner_hs <= 1'b0;
                  wait_cnt <= '0;
               end else if (hold_cnt == HOLD_LAST) begin
                  state     <= RELEASE;
                  owner_hs  <= 1'b0;
                  pause_req <= 1'b0;
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            RELEASE: begin
               state    <= IDLE;
               owner_hs <= 1'b0;
            end
            default: begin
               state     <= IDLE;
               owner_hs  <= 1'b0;
               pause_req <= 1'b0;
            end
         endcase
      end
   end

   // While the engine owns the RAM the CPU write strobe is dropped entirely.
   assign ram_addr  = owner_hs ? hs.hs_addr  : cpu_addr;
   assign ram_wdata = owner_hs ? hs.hs_wdata : cpu_wdata;
   assign ram_we    = owner_hs ? ((state == ACCESS) && hs.hs_we) : cpu_we;
   assign cpu_rdata = ram_q;

endmodule

// File: tb/tb_hiscore_ram_arbiter.sv
// Self-checking bench for hiscore_ram_arbiter: RAM environment, shadow memory
// reference and scenario tasks run in sequence.
module tb_hiscore_ram_arbiter;

   localparam int AW       = 12;
   localparam int HOLD_CYC = 4;
   localparam int TMO_CYC  = 16;
   localparam int DEPTH    = 1 << AW;

   logic          clk_sys = 1'b0;
   logic          reset_n = 1'b0;
   logic [AW-1:0] cpu_addr;
   logic [7:0]    cpu_wdata;
   logic          cpu_we;
   logic [7:0]    cpu_rdata;
   logic          pause_req;
   logic          cpu_paused;
   logic [AW-1:0] ram_addr;
   logic [7:0]    ram_wdata;
   logic          ram_we;
   logic [7:0]    ram_q;
   logic          hs_err;

   hiscore_ram_arbiter_if #(.AW(AW)) hs_bus ();

   hiscore_ram_arbiter #(.AW(AW), .HOLD_CYC(HOLD_CYC), .TMO_CYC(TMO_CYC)) dut (
      .clk_sys    (clk_sys),
      .reset_n    (reset_n),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_we     (cpu_we),
      .cpu_rdata  (cpu_rdata),
      .hs         (hs_bus),
      .pause_req  (pause_req),
      .cpu_paused (cpu_paused),
      .ram_addr   (ram_addr),
      .ram_wdata  (ram_wdata),
      .ram_we     (ram_we),
      .ram_q      (ram_q),
      .hs_err     (hs_err)
   );

   always #5 clk_sys = ~clk_sys;

   int checks = 0;
   int errors = 0;
   int we_cnt = 0;
   int ack_cnt = 0;
   logic [7:0] ram_mem [0:DEPTH-1];
   logic [7:0] exp_mem [0:DEPTH-1];

   // Synchronous single-port RAM, read-before-write, plus event counters
   always @(posedge clk_sys) begin
      if (ram_we) ram_mem[ram_addr] <= ram_wdata;
      ram_q <= ram_mem[ram_addr];
      if (ram_we) we_cnt <= we_cnt + 1;
      if (hs_bus.hs_ack) ack_cnt <= ack_cnt + 1;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog");
   end

   // Drives one complete engine access and reports what it observed.
   task automatic hs_single(input logic we, input logic [AW-1:0] addr, input logic [7:0] wd,
                            input int pdly, output int pause_lat, output int ack_lat,
                            output int hold_len, output logic [7:0] rd, output bit tmo);
      int n;
      tmo = 1'b0;
      @(negedge clk_sys);
      hs_bus.hs_req = 1'b1; hs_bus.hs_we = we; hs_bus.hs_addr = addr; hs_bus.hs_wdata = wd;
      n = 0;
      do begin @(negedge clk_sys); n++; end while (!pause_req && n < 64);
      pause_lat = n;
      if (!pause_req) tmo = 1'b1;
      repeat (pdly) @(negedge clk_sys);
      cpu_paused = 1'b1;
      n = 0;
      do begin @(negedge clk_sys); n++; end while (!hs_bus.hs_ack && n < 64);
      ack_lat = n;
      if (!hs_bus.hs_ack) tmo = 1'b1;
      hs_bus.hs_req = 1'b0;
      @(negedge clk_sys);
      rd = hs_bus.hs_rdata;
      n = 1;
      while (pause_req && n < 64) begin @(negedge clk_sys); n++; end
      hold_len = n;
      if (pause_req) tmo = 1'b1;
      cpu_paused = 1'b0;
      @(negedge clk_sys);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      hs_bus.hs_req = 1'b1;
      cpu_we = 1'b1; cpu_addr = 12'h055; cpu_wdata = 8'h11;
      #2;
      checks++; if (pause_req !== 1'b0) begin errors++; $display("FAIL reset_pause: got %b expected 0", pause_req); end
      checks++; if (hs_bus.hs_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0", hs_bus.hs_ack); end
      checks++; if (hs_bus.hs_rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h expected 00", hs_bus.hs_rdata); end
      checks++; if (hs_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", hs_err); end
      checks++; if (ram_addr !== 12'h055 || ram_we !== 1'b1) begin errors++; $display("FAIL reset_owner_cpu: got addr %h we %b expected 055 1", ram_addr, ram_we); end
      repeat (3) @(negedge clk_sys);
      exp_mem[12'h055] = 8'h11;
      checks++; if (pause_req !== 1'b0) begin errors++; $display("FAIL reset_held_pause: got %b expected 0", pause_req); end
      hs_bus.hs_req = 1'b0; cpu_we = 1'b0;
      reset_n = 1'b1;
      repeat (4) @(negedge clk_sys);
   endtask

   task automatic test_cpu_only();
      logic [AW-1:0] a;
      logic [7:0]    d;
      @(negedge clk_sys);
      cpu_we = 1'b1; cpu_addr = 12'h123; cpu_wdata = 8'h5A;
      #1;
      checks++; if (ram_we !== 1'b1 || ram_addr !== 12'h123 || ram_wdata !== 8'h5A) begin
         errors++; $display("FAIL cpu_pass: got we %b addr %h d %h expected 1 123 5a", ram_we, ram_addr, ram_wdata); end
      exp_mem[12'h123] = 8'h5A;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk_sys);
         a = AW'(12'h400 + $urandom_range(0, 255)); d = 8'($urandom);
         cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
         exp_mem[a] = d;
         @(negedge clk_sys);
         cpu_we = 1'b0;
         @(negedge clk_sys);
         checks++; if (cpu_rdata !== exp_mem[a]) begin errors++; $display("FAIL cpu_readback[%0d]: got %h expected %h", i, cpu_rdata, exp_mem[a]); end
         checks++; if (pause_req !== 1'b0) begin errors++; $display("FAIL cpu_pause[%0d]: got %b expected 0", i, pause_req); end
      end
      cpu_addr = 12'h123;
      @(negedge clk_sys);
      checks++; if (cpu_rdata !== 8'h5A) begin errors++; $display("FAIL cpu_read_123: got %h expected 5a", cpu_rdata); end
   endtask

   task automatic test_hs_read();
      int pl, al, hl, a0, w0;
      logic [7:0] rd;
      bit tmo;
      a0 = ack_cnt; w0 = we_cnt;
      hs_single(1'b0, 12'h200, 8'h00, 3, pl, al, hl, rd, tmo);
      checks++; if (tmo) begin errors++; $display("FAIL hs_read_timeout: got stuck expected completion"); end
      checks++; if (pl !== 1) begin errors++; $display("FAIL hs_read_pause_lat: got %0d expected 1", pl); end
      checks++; if (al !== 2) begin errors++; $display("FAIL hs_read_ack_lat: got %0d expected 2", al); end
      checks++; if (rd !== exp_mem[12'h200]) begin errors++; $display("FAIL hs_read_data: got %h expected %h", rd, exp_mem[12'h200]); end
      checks++; if (hl !== HOLD_CYC + 1) begin errors++; $display("FAIL hs_read_hold: got %0d expected %0d", hl, HOLD_CYC + 1); end
      checks++; if (ack_cnt - a0 !== 1 || we_cnt - w0 !== 0) begin
         errors++; $display("FAIL hs_read_counts: got ack %0d we %0d expected 1 0", ack_cnt - a0, we_cnt - w0); end
   endtask

   task automatic test_random();
      int pl, al, hl, a0, w0;
      logic [7:0] rd, wd;
      logic [AW-1:0] a;
      logic we;
      bit tmo;
      for (int i = 0; i < 12; i++) begin
         a  = AW'(12'h100 + $urandom_range(0, 7));
         we = 1'($urandom_range(0, 1));
         wd = 8'($urandom);
         a0 = ack_cnt; w0 = we_cnt;
         hs_single(we, a, wd, int'($urandom_range(0, 4)), pl, al, hl, rd, tmo);
         checks++; if (tmo || al !== 2 || pl !== 1 || hl !== HOLD_CYC + 1) begin
            errors++; $display("FAIL rand_timing[%0d]: got tmo %0d pause %0d ack %0d hold %0d expected 0 1 2 %0d", i, tmo, pl, al, hl, HOLD_CYC + 1); end
         checks++; if (ack_cnt - a0 !== 1 || we_cnt - w0 !== int'(we)) begin
            errors++; $display("FAIL rand_counts[%0d]: got ack %0d we %0d expected 1 %0d", i, ack_cnt - a0, we_cnt - w0, we); end
         if (we) begin
            exp_mem[a] = wd;
            checks++; if (ram_mem[a] !== exp_mem[a]) begin errors++; $display("FAIL rand_write[%0d]: got %h expected %h", i, ram_mem[a], exp_mem[a]); end
         end else begin
            checks++; if (rd !== exp_mem[a]) begin errors++; $display("FAIL rand_read[%0d]: got %h expected %h", i, rd, exp_mem[a]); end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] bd [4];
      int ack_at [4];
      int idx, n, a0, w0;
      bit gap;
      a0 = ack_cnt; w0 = we_cnt;
      cpu_addr = 12'hABC; cpu_wdata = 8'hEE; cpu_we = 1'b0;
      for (int i = 0; i < 4; i++) begin bd[i] = 8'($urandom); ack_at[i] = -1; end
      @(negedge clk_sys);
      hs_bus.hs_req = 1'b1; hs_bus.hs_we = 1'b1; hs_bus.hs_addr = 12'h300; hs_bus.hs_wdata = bd[0];
      n = 0;
      do begin @(negedge clk_sys); n++; end while (!pause_req && n < 64);
      cpu_paused = 1'b1;
      @(negedge clk_sys);
      cpu_we = 1'b1;
      idx = 0; n = 1; gap = 1'b0;
      while (idx < 4 && n < 64) begin
         if (!pause_req) gap = 1'b1;
         if (hs_bus.hs_ack) begin
            ack_at[idx] = n;
            idx++;
            if (idx < 4) begin
               hs_bus.hs_addr = AW'(12'h300 + idx); hs_bus.hs_wdata = bd[idx];
            end else begin
               hs_bus.hs_req = 1'b0; cpu_we = 1'b0;
            end
         end
         @(negedge clk_sys);
         n++;
      end
      n = 0;
      while (pause_req && n < 64) begin @(negedge clk_sys); n++; end
      cpu_paused = 1'b0;
      checks++; if (idx !== 4) begin errors++; $display("FAIL burst_acks: got %0d expected 4", idx); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (ack_at[i] !== 2 + 2 * i) begin errors++; $display("FAIL burst_ack_cycle[%0d]: got %0d expected %0d", i, ack_at[i], 2 + 2 * i); end
         exp_mem[12'h300 + i] = bd[i];
         checks++; if (ram_mem[12'h300 + i] !== exp_mem[12'h300 + i]) begin
            errors++; $display("FAIL burst_data[%0d]: got %h expected %h", i, ram_mem[12'h300 + i], exp_mem[12'h300 + i]); end
      end
      checks++; if (gap) begin errors++; $display("FAIL burst_pause_gap: got drop expected continuous"); end
      checks++; if (we_cnt - w0 !== 4 || ack_cnt - a0 !== 4) begin
         errors++; $display("FAIL burst_counts: got we %0d ack %0d expected 4 4", we_cnt - w0, ack_cnt - a0); end
      checks++; if (ram_mem[12'hABC] !== exp_mem[12'hABC]) begin errors++; $display("FAIL burst_cpu_blocked: got %h expected %h", ram_mem[12'hABC], exp_mem[12'hABC]); end
      @(negedge clk_sys);
   endtask

   task automatic test_rehandshake();
      int n, w0;
      bit early;
      w0 = we_cnt; cpu_addr = 12'h777; cpu_we = 1'b0;
      @(negedge clk_sys);
      hs_bus.hs_req = 1'b1; hs_bus.hs_we = 1'b1; hs_bus.hs_addr = 12'h320; hs_bus.hs_wdata = 8'h91;
      n = 0;
      do begin @(negedge clk_sys); n++; end while (!pause_req && n < 64);
      cpu_paused = 1'b1;
      @(negedge clk_sys);
      cpu_paused = 1'b0;
      n = 1;
      do begin @(negedge clk_sys); n++; end while (!hs_bus.hs_ack && n < 64);
      checks++; if (n !== 2) begin errors++; $display("FAIL rehs_first_ack: got %0d expected 2", n); end
      hs_bus.hs_addr = 12'h321; hs_bus.hs_wdata = 8'h92;
      early = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_sys);
         if (hs_bus.hs_ack || !pause_req) early = 1'b1;
      end
      checks++; if (early) begin errors++; $display("FAIL rehs_wait: got ack or pause drop expected PREQ wait"); end
      checks++; if (ram_addr !== 12'h777) begin errors++; $display("FAIL rehs_owner: got %h expected 777", ram_addr); end
      cpu_paused = 1'b1;
      n = 0;
      do begin @(negedge clk_sys); n++; end while (!hs_bus.hs_ack && n < 64);
      checks++; if (n !== 2) begin errors++; $display("FAIL rehs_second_ack: got %0d expected 2", n); end
      hs_bus.hs_req = 1'b0;
      n = 0;
      while (pause_req && n < 64) begin @(negedge clk_sys); n++; end
      cpu_paused = 1'b0;
      exp_mem[12'h320] = 8'h91; exp_mem[12'h321] = 8'h92;
      checks++; if (ram_mem[12'h320] !== exp_mem[12'h320] || ram_mem[12'h321] !== exp_mem[12'h321] || we_cnt - w0 !== 2) begin
         errors++; $display("FAIL rehs_data: got %h %h we %0d expected 91 92 2", ram_mem[12'h320], ram_mem[12'h321], we_cnt - w0); end
      @(negedge clk_sys);
   endtask

   task automatic test_abort();
      int a0, w0;
      a0 = ack_cnt; w0 = we_cnt;
      @(negedge clk_sys);
      hs_bus.hs_req = 1'b1; hs_bus.hs_we = 1'b1; hs_bus.hs_addr = 12'h330; hs_bus.hs_wdata = 8'h44;
      repeat (2) @(negedge clk_sys);
      checks++; if (pause_req !== 1'b1) begin errors++; $display("FAIL abort_preq: got %b expected 1", pause_req); end
      hs_bus.hs_req = 1'b0;
      @(negedge clk_sys);
      checks++; if (pause_req !== 1'b0) begin errors++; $display("FAIL abort_release: got %b expected 0", pause_req); end
      repeat (2) @(negedge clk_sys);
      checks++; if (ack_cnt - a0 !== 0 || we_cnt - w0 !== 0 || hs_err !== 1'b0 || pause_req !== 1'b0) begin
         errors++; $display("FAIL abort_idle: got ack %0d we %0d err %b pause %b expected 0 0 0 0", ack_cnt - a0, we_cnt - w0, hs_err, pause_req); end
   endtask

   task automatic test_timeout();
      int n, a0, w0, pl, al, hl;
      logic [7:0] rd;
      bit tmo;
      a0 = ack_cnt; w0 = we_cnt;
      cpu_paused = 1'b0; cpu_we = 1'b0;
      @(negedge clk_sys);
      hs_bus.hs_req = 1'b1; hs_bus.hs_we = 1'b1; hs_bus.hs_addr = 12'h340; hs_bus.hs_wdata = 8'h66;
      n = 0;
      do begin @(negedge clk_sys); n++; end while (!pause_req && n < 64);
      n = 0;
      while (pause_req && n < 200) begin n++; @(negedge clk_sys); end
      hs_bus.hs_req = 1'b0;
      checks++; if (n !== TMO_CYC) begin errors++; $display("FAIL tmo_cycles: got %0d expected %0d", n, TMO_CYC); end
      checks++; if (hs_err !== 1'b1) begin errors++; $display("FAIL tmo_err: got %b expected 1", hs_err); end
      repeat (3) @(negedge clk_sys);
      checks++; if (hs_err !== 1'b1 || pause_req !== 1'b0) begin errors++; $display("FAIL tmo_sticky: got err %b pause %b expected 1 0", hs_err, pause_req); end
      checks++; if (ack_cnt - a0 !== 0 || we_cnt - w0 !== 0) begin errors++; $display("FAIL tmo_no_access: got ack %0d we %0d expected 0 0", ack_cnt - a0, we_cnt - w0); end
      hs_single(1'b0, 12'h200, 8'h00, 1, pl, al, hl, rd, tmo);
      checks++; if (tmo || pl !== 1 || rd !== exp_mem[12'h200]) begin
         errors++; $display("FAIL tmo_recover: got tmo %0d pause %0d data %h expected 0 1 %h", tmo, pl, rd, exp_mem[12'h200]); end
   endtask

   task automatic test_reset_mid_burst();
      int n, pl, al, hl, w0;
      logic [7:0] rd;
      logic [2:0] seen;
      bit tmo;
      hs_single(1'b0, 12'h200, 8'h00, 0, pl, al, hl, rd, tmo);
      cpu_addr = 12'h777; cpu_we = 1'b0;
      @(negedge clk_sys);
      hs_bus.hs_req = 1'b1; hs_bus.hs_we = 1'b1; hs_bus.hs_addr = 12'h310; hs_bus.hs_wdata = 8'h3C;
      n = 0;
      do begin @(negedge clk_sys); n++; end while (!pause_req && n < 64);
      cpu_paused = 1'b1;
      @(negedge clk_sys);
      checks++; if (ram_we !== 1'b1 || ram_addr !== 12'h310) begin errors++; $display("FAIL mid_access: got we %b addr %h expected 1 310", ram_we, ram_addr); end
      w0 = we_cnt;
      reset_n = 1'b0;
      #1;
      checks++; if (pause_req !== 1'b0 || ram_we !== 1'b0 || ram_addr !== 12'h777 || hs_bus.hs_rdata !== 8'h00) begin
         errors++; $display("FAIL mid_reset: got pause %b we %b addr %h rdata %h expected 0 0 777 00", pause_req, ram_we, ram_addr, hs_bus.hs_rdata); end
      cpu_paused = 1'b0;
      repeat (3) @(negedge clk_sys);
      checks++; if (we_cnt - w0 !== 0 || ram_mem[12'h310] !== exp_mem[12'h310] || hs_err !== 1'b0) begin
         errors++; $display("FAIL mid_no_write: got we %0d mem %h err %b expected 0 %h 0", we_cnt - w0, ram_mem[12'h310], hs_err, exp_mem[12'h310]); end
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_sys);
         seen[i] = pause_req;
      end
      checks++; if (seen !== 3'b100) begin errors++; $display("FAIL reset_sync_release: got %b expected 100", seen); end
      hs_bus.hs_req = 1'b0;
      repeat (3) @(negedge clk_sys);
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         ram_mem[i] = 8'h00;
         exp_mem[i] = 8'h00;
      end
      ram_mem[12'h200] = 8'hA7;
      exp_mem[12'h200] = 8'hA7;
      cpu_addr = '0; cpu_wdata = '0; cpu_we = 1'b0; cpu_paused = 1'b0;
      hs_bus.hs_req = 1'b0; hs_bus.hs_addr = '0; hs_bus.hs_we = 1'b0; hs_bus.hs_wdata = '0;

      test_reset();
      test_cpu_only();
      test_hs_read();
      test_random();
      test_back_to_back();
      test_rehandshake();
      test_abort();
      test_timeout();
      test_reset_mid_burst();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
